uart_tx_n: RTL and testbench
============================

Name: uart_tx_n

Overview:
UART transmitter, the transmit-side counterpart of the team's UART receive shift register.
- A write port buffers bytes into a small synchronous FIFO.
- A baud-tick counter plus a frame FSM serialise each byte onto tx_o.
- Frame format: start bit 0, 8 data bits LSB first, 1 stop bit 1. Line idles high.
- The format matches what the receive shift register expects (9-bit start+data capture, first data bit = LSB).

Parameters:
CLKS_PER_BIT, 16, clk_i cycles per serial bit; legal range 2..65535.
DEPTH, 8, FIFO entries; power of 2, at least 2.
DATA_W, 8, data bits per frame; fixed at 8, exposed for the package constant only.

Ports:
clk_i  in  1  system clock; all logic is rising-edge.
rst_i  in  1  synchronous, active-high reset.
data_i  in  8  byte to transmit.
wr_i  in  1  write strobe; the byte is accepted when wr_i=1 and full_o=0.
full_o  out  1  FIFO full; occupancy == DEPTH.
empty_o  out  1  FIFO empty; occupancy == 0.
ovf_o  out  1  sticky overflow: set when wr_i=1 while full_o=1; cleared only by rst_i.
tx_o  out  1  serial line, registered output.
busy_o  out  1  1 whenever the FSM is not in IDLE.
done_o  out  1  one-cycle pulse on the last clk_i of each stop bit.

Behaviour:
- Reset values (rst_i=1 sampled at an edge): tx_o=1, busy_o=0, done_o=0, ovf_o=0, empty_o=1, full_o=0. FIFO pointers, occupancy, baud counter and bit counter all go to 0; FSM goes to IDLE.
- Reset mid-frame aborts the frame immediately: tx_o=1 on the next cycle and FIFO contents are discarded.
- FIFO write:
  - If wr_i=1 and full_o=0 at edge T, data_i is stored and occupancy increments; visible at T+1.
  - A write while full is dropped and sets ovf_o, even if a pop happens in the same cycle. full_o is the registered state, not a look-ahead.
- Simultaneous push and pop leaves occupancy unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx_o=1.
  - If empty_o=0, pop the head into the 8-bit shift register, clear the baud counter, and go to START.
  - Latency: a write at edge T into an empty idle block drives tx_o=0 from edge T+2.
- START:
  - tx_o=0 for CLKS_PER_BIT cycles.
  - When baud counter == CLKS_PER_BIT-1: counter → 0, bit counter → 0, go to DATA.
- DATA:
  - tx_o = shreg[0].
  - On each baud terminal count: shreg shifts right and the bit counter increments.
  - After bit 7's terminal count, go to STOP.
- STOP:
  - tx_o=1 for CLKS_PER_BIT cycles.
  - done_o=1 in the terminal-count cycle.
  - If empty_o=0 in that same cycle, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Bit transitions align exactly to baud terminal counts; there is no jitter.
- The baud counter runs only when busy_o=1 and is held at 0 in IDLE.
- tx_o is glitch-free because it is driven from a flop.
- busy_o=1 in START, DATA and STOP.
- Writes during transmission are allowed and do not disturb the frame in flight.

Decomposition:
- Package uart_pkg:
  - state enum tx_state_t {IDLE, START, DATA, STOP}.
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LVL=1'b1, DATA_BITS=8.
  - The receive-side register shares these constants.
- One sub-module: sync_fifo_n.
  - Single-clock FIFO with parameters width and depth.
  - Ports: push, pop, din, dout, full, empty; same clk_i/rst_i.
  - Must not be confused with the existing asynchronous FIFO.
- Baud counter, bit counter and FSM live in uart_tx_n.

Test Plan:
- Reset check: hold rst_i=1 for 3 cycles, then release → tx_o=1, empty_o=1, busy_o=0, ovf_o=0. Hold idle 100 cycles → tx_o stays 1.
- Single byte (CLKS_PER_BIT=4): write 8'hA5 at edge T.
  - tx_o=0 from T+2 for 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - done_o pulses once at T+41; busy_o falls at T+42.
- Back-to-back: write 8'h00 then 8'hFF on consecutive cycles → two frames with no idle cycle between the stop bit and the next start bit. Total time from the first start bit to the last done_o is 80 cycles.
- Full/overflow (DEPTH=8): write 10 bytes on consecutive cycles starting from idle.
  - The first is popped, 8 are buffered, so full_o=1.
  - The 10th write is dropped and ovf_o=1 (sticky).
  - Serial output is bytes 1-9 in order; byte 10 never appears.
- Reset mid-frame: assert rst_i during DATA bit 3 of 8'h3C → next cycle tx_o=1, busy_o=0, empty_o=1. No done_o pulse is emitted.
- Loopback: connect tx_o to the receive register running at a matching bit period, send 8'h55, 8'h81, 8'h7E → the receiver presents the same three bytes in order.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Constants and types shared by the UART transmit and receive blocks.
//   tx_state_t : frame FSM states (IDLE, START, DATA, STOP)
//   START_BIT / STOP_BIT / IDLE_LVL : serial line levels
//   DATA_BITS  : data bits per frame, LSB sent first
//   clog2_min1 : index width helper that never returns 0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Width needed to index 'value' entries, clamped to at least one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/sync_fifo_n.sv
// ---------------------------------------------------------------------------
// sync_fifo_n
// Single-clock FIFO (not the clock-crossing FIFO). Read data is presented
// combinationally from the head entry, so a pop consumes dout_o in the same
// cycle it is asserted.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset (empties the FIFO)
//   push_i   : write strobe, ignored while full_o=1
//   pop_i    : read strobe, ignored while empty_o=1
//   din_i    : write data
//   dout_o   : head-of-queue data
//   full_o   : occupancy == DEPTH (registered state)
//   empty_o  : occupancy == 0 (registered state)
// ---------------------------------------------------------------------------
module sync_fifo_n
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW    = clog2_min1(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  // Gated against the registered flags, so a push while full is dropped even
  // when a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value of the others, independent of statement order.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_n.sv
// ---------------------------------------------------------------------------
// uart_tx_n
// UART transmitter: bytes are queued in a sync_fifo_n and serialised as
// start(0), 8 data bits LSB first, stop(1). Line idles high.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset; aborts any frame in flight
//   data_i  : byte to transmit
//   wr_i    : write strobe, accepted when full_o=0
//   full_o  : FIFO full
//   empty_o : FIFO empty
//   ovf_o   : sticky, set by a write while full; cleared only by reset
//   tx_o    : serial line (flop output)
//   busy_o  : frame in progress
//   done_o  : one-cycle pulse on the last clock of each stop bit
// tx_o, busy_o and done_o are registered from the current FSM state, so they
// all trail the state register by one cycle and stay mutually aligned.
// ---------------------------------------------------------------------------
module uart_tx_n
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8,
  parameter int DATA_W       = DATA_BITS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wr_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              ovf_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CW = clog2_min1(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    BIT_ONE   = 3'd1;

  tx_state_t         state_q, state_d;
  logic [CW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              pop;
  logic [DATA_W-1:0] fifo_dout;
  logic              baud_tick;

  sync_fifo_n #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wr_i),
    .pop_i   (pop),
    .din_i   (data_i),
    .dout_o  (fifo_dout),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  assign baud_tick = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_ONE;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty_o) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + BIT_ONE;
        end
      end
      STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          done_d = 1'b1;
          // Chain straight into the next start bit when more data waits.
          if (!empty_o) begin
            pop     = 1'b1;
            shreg_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

    unique case (state_q)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shreg_q[0];
      STOP:    tx_d = STOP_BIT;
      default: tx_d = IDLE_LVL;
    endcase

    busy_d = (state_q != IDLE);
    ovf_d  = ovf_q | (wr_i & full_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_uart_tx_n.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_n
// Directed bench for uart_tx_n with CLKS_PER_BIT=4, DEPTH=8. Accepted bytes
// are pushed onto a scoreboard queue; a serial receiver model decodes tx_o
// (mid-bit sampling) and compares each received byte against the queue head.
// ---------------------------------------------------------------------------
module tb_uart_tx_n;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] data_i = '0;
  logic       wr_i = 1'b0;
  logic       full_o, empty_o, ovf_o, tx_o, busy_o, done_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [$];
  logic       mon_en = 1'b0;

  logic tr_tx   [0:99];
  logic tr_busy [0:99];
  logic tr_done [0:99];

  uart_tx_n #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH),
    .DATA_W       (8)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .wr_i    (wr_i),
    .full_o  (full_o),
    .empty_o (empty_o),
    .ovf_o   (ovf_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns 1 time unit after the rising edge, when outputs have settled.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one write strobe across a single edge; returns just after it.
  task automatic write_byte(input logic [7:0] b, input logic expect_sent);
    data_i = b;
    wr_i   = 1'b1;
    if (expect_sent) sb.push_back(b);
    tick();
    wr_i   = 1'b0;
  endtask

  task automatic record(input int k);
    tr_tx[k]   = tx_o;
    tr_busy[k] = busy_o;
    tr_done[k] = done_o;
  endtask

  task automatic capture(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      tick();
      record(k);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    repeat (3) tick();
    while (!(busy_o === 1'b0 && empty_o === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    check(tag, n < budget, 1'b1);
    repeat (4) tick();
  endtask

  // Serial receiver model: samples at edge+2 so it never races the driver.
  task automatic mon_wait(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] exp_b;
    forever begin
      mon_wait(1);
      if (mon_en && !rst_i && tx_o === 1'b0) begin
        mon_wait(CPB / 2);
        check("rx_start_bit", tx_o, 1'b0);
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB);
          rx[i] = tx_o;
        end
        mon_wait(CPB);
        check("rx_stop_bit", tx_o, 1'b1);
        check("rx_sb_has_entry", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          exp_b = sb.pop_front();
          check("rx_byte", rx, exp_b);
        end
      end
    end
  end

  initial begin
    logic [9:0] frame;
    int         cnt;
    int         zeros;

    // ---------------- reset ----------------
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    check("rst_tx", tx_o, 1'b1);
    check("rst_empty", empty_o, 1'b1);
    check("rst_full", full_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ovf", ovf_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    zeros = 0;
    repeat (100) begin
      tick();
      if (tx_o !== 1'b1) zeros++;
    end
    check("idle_tx_held_high", zeros, 0);
    mon_en = 1'b1;

    // ---------------- single byte A5 ----------------
    write_byte(8'hA5, 1'b1);
    record(0);
    capture(1, 45);
    frame = {1'b1, 8'hA5, 1'b0};
    check("a5_tx_before_start", tr_tx[1], 1'b1);
    check("a5_busy_before_start", tr_busy[1], 1'b0);
    check("a5_busy_rise", tr_busy[2], 1'b1);
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < CPB; j++)
        check($sformatf("a5_bit%0d_cyc%0d", i, j), tr_tx[2 + CPB * i + j], frame[i]);
    check("a5_tx_after_stop", tr_tx[42], 1'b1);
    cnt = 0;
    for (int k = 0; k <= 45; k++) if (tr_done[k] === 1'b1) cnt++;
    check("a5_done_count", cnt, 1);
    check("a5_done_t41", tr_done[41], 1'b1);
    check("a5_busy_t41", tr_busy[41], 1'b1);
    check("a5_busy_fall_t42", tr_busy[42], 1'b0);
    wait_idle("a5_drain", 200);
    check("a5_sb_empty", sb.size(), 0);

    // ---------------- back-to-back 00, FF ----------------
    write_byte(8'h00, 1'b1);
    record(0);
    write_byte(8'hFF, 1'b1);
    record(1);
    capture(2, 85);
    check("b2b_stop1_high", tr_tx[41], 1'b1);
    check("b2b_start2_t42", tr_tx[42], 1'b0);
    check("b2b_done1_t41", tr_done[41], 1'b1);
    check("b2b_done2_t81", tr_done[81], 1'b1);
    cnt = 0;
    zeros = 0;
    for (int k = 0; k <= 85; k++) if (tr_done[k] === 1'b1) cnt++;
    for (int k = 2; k <= 81; k++) if (tr_busy[k] !== 1'b1) zeros++;
    check("b2b_done_count", cnt, 2);
    check("b2b_no_idle_gap", zeros, 0);
    check("b2b_busy_fall_t82", tr_busy[82], 1'b0);
    wait_idle("b2b_drain", 300);
    check("b2b_sb_empty", sb.size(), 0);

    // ---------------- fill and overflow ----------------
    for (int i = 0; i < 10; i++) begin
      write_byte(8'h10 + 8'(i), i < 9);
      if (i == 7) check("ovf_not_full_at_7", full_o, 1'b0);
      if (i == 8) begin
        check("ovf_full_at_8", full_o, 1'b1);
        check("ovf_clear_at_8", ovf_o, 1'b0);
      end
      if (i == 9) begin
        check("ovf_full_at_9", full_o, 1'b1);
        check("ovf_set_at_9", ovf_o, 1'b1);
      end
    end
    wait_idle("ovf_drain", 800);
    check("ovf_sticky", ovf_o, 1'b1);
    check("ovf_empty_after", empty_o, 1'b1);
    check("ovf_sb_empty", sb.size(), 0);

    // ---------------- reset mid-frame ----------------
    mon_en = 1'b0;
    write_byte(8'h3C, 1'b0);
    write_byte(8'h99, 1'b0);
    repeat (18) tick();
    check("mid_busy_before_rst", busy_o, 1'b1);
    check("mid_fifo_nonempty", empty_o, 1'b0);
    rst_i = 1'b1;
    tick();
    check("mid_rst_tx", tx_o, 1'b1);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_empty", empty_o, 1'b1);
    check("mid_rst_done", done_o, 1'b0);
    check("mid_rst_ovf", ovf_o, 1'b0);
    rst_i = 1'b0;
    cnt = 0;
    zeros = 0;
    repeat (60) begin
      tick();
      if (done_o === 1'b1) cnt++;
      if (tx_o !== 1'b1) zeros++;
    end
    check("mid_no_done", cnt, 0);
    check("mid_line_idle", zeros, 0);

    // ---------------- loopback ----------------
    mon_en = 1'b1;
    write_byte(8'h55, 1'b1);
    write_byte(8'h81, 1'b1);
    write_byte(8'h7E, 1'b1);
    wait_idle("loop_drain", 400);
    check("loop_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
